// File: rtl/sensor_gen_pkg.sv
// Shared types and constants for the parking-lot sensor sequence generator.
// Sensor patterns are packed as {a, b}.
package sensor_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PH1  = 3'd1,
        PH2  = 3'd2,
        PH3  = 3'd3,
        GAP  = 3'd4
    } state_t;

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    localparam logic [1:0] PAT_IDLE      = 2'b00;
    localparam logic [1:0] PAT_ENTRY_PH1 = 2'b10;
    localparam logic [1:0] PAT_ENTRY_PH2 = 2'b11;
    localparam logic [1:0] PAT_ENTRY_PH3 = 2'b01;
    localparam logic [1:0] PAT_EXIT_PH1  = 2'b01;
    localparam logic [1:0] PAT_EXIT_PH2  = 2'b11;
    localparam logic [1:0] PAT_EXIT_PH3  = 2'b10;

    // Sensor pattern shown while in state st for a car travelling in direction d.
    function automatic logic [1:0] phase_pattern(input state_t st, input logic d);
        logic [1:0] pat;
        pat = PAT_IDLE;
        case (st)
            PH1:     pat = (d == DIR_EXIT) ? PAT_EXIT_PH1 : PAT_ENTRY_PH1;
            PH2:     pat = (d == DIR_EXIT) ? PAT_EXIT_PH2 : PAT_ENTRY_PH2;
            PH3:     pat = (d == DIR_EXIT) ? PAT_EXIT_PH3 : PAT_ENTRY_PH3;
            default: pat = PAT_IDLE;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/sensor_gen_if.sv
// Request/sensor bundle between a requester (master) and the generator (slave).
// Handshake: enter_req/exit_req are fire-and-forget strobes, one car per high cycle; no ready.
interface sensor_gen_if;
    logic enter_req;
    logic exit_req;
    logic a;
    logic b;
    logic busy;
    logic done;
    logic dir;
    logic ovf;

    modport master (
        output enter_req, exit_req,
        input  a, b, busy, done, dir, ovf
    );

    modport slave (
        input  enter_req, exit_req,
        output a, b, busy, done, dir, ovf
    );
endinterface

// File: rtl/pend_counter.sv
// Saturating pending-request counter; drop flags a request lost at saturation.
// The caller only asserts dec when count is non-zero.
module pend_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         drop
);

    localparam logic [W-1:0] MAX = '1;

    // A simultaneous inc/dec cancels, so it can never drop even when full.
    assign drop = inc && !dec && (count == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && (count != MAX)) begin
            count <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sensor_sequence_generator.sv
// Plays back legal outer/inner sensor sequences (a, b) for queued entering and
// leaving cars, one car at a time, with fixed phase and gap timing.
module sensor_sequence_generator
    import sensor_gen_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    sensor_gen_if.slave  bus,
    output state_t       fsm_state
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(1);

    state_t            state;
    logic [TW-1:0]     timer;
    logic              a_q, b_q, busy_q, done_q, dir_q, ovf_q;
    logic              last_dir;

    logic [PEND_W-1:0] cnt_entry, cnt_exit;
    logic              drop_entry, drop_exit;
    logic              dec_entry, dec_exit;
    logic              launch, pick_exit;

    pend_counter #(.W(PEND_W)) u_pend_entry (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.enter_req),
        .dec   (dec_entry),
        .count (cnt_entry),
        .drop  (drop_entry)
    );

    pend_counter #(.W(PEND_W)) u_pend_exit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.exit_req),
        .dec   (dec_exit),
        .count (cnt_exit),
        .drop  (drop_exit)
    );

    // With both directions pending, serve the one opposite to the last car.
    always_comb begin
        pick_exit = 1'b0;
        if ((cnt_entry != '0) && (cnt_exit != '0)) begin
            pick_exit = (last_dir == DIR_ENTRY);
        end else begin
            pick_exit = (cnt_exit != '0);
        end
        launch    = (state == IDLE) && (timer == '0) &&
                    ((cnt_entry != '0) || (cnt_exit != '0));
        dec_entry = launch && !pick_exit;
        dec_exit  = launch && pick_exit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dir_q    <= DIR_ENTRY;
            ovf_q    <= 1'b0;
            last_dir <= DIR_EXIT;
        end else begin
            done_q <= 1'b0;
            ovf_q  <= drop_entry | drop_exit;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state      <= PH1;
                        timer      <= HOLD_LOAD;
                        dir_q      <= pick_exit;
                        last_dir   <= pick_exit;
                        {a_q, b_q} <= phase_pattern(PH1, pick_exit);
                        busy_q     <= 1'b1;
                    end else if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end
                end
                PH1: begin
                    if (timer == '0) begin
                        state      <= PH2;
                        timer      <= HOLD_LOAD;
                        {a_q, b_q} <= phase_pattern(PH2, dir_q);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                PH2: begin
                    if (timer == '0) begin
                        state      <= PH3;
                        timer      <= HOLD_LOAD;
                        {a_q, b_q} <= phase_pattern(PH3, dir_q);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                PH3: begin
                    if (timer == '0) begin
                        state      <= GAP;
                        timer      <= GAP_LOAD;
                        {a_q, b_q} <= PAT_IDLE;
                        done_q     <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                GAP: begin
                    // One settle cycle in IDLE keeps consecutive cars 2 cycles past GAP.
                    if (timer == '0) begin
                        state  <= IDLE;
                        timer  <= SETTLE_LOAD;
                        busy_q <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    timer      <= '0;
                    {a_q, b_q} <= PAT_IDLE;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a     = a_q;
    assign bus.b     = b_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.dir   = dir_q;
    assign bus.ovf   = ovf_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_sensor_sequence_generator.sv
// Directed bench for sensor_sequence_generator, including a closed loop through
// a small entry/exit detector model driven by the generated a/b.
module tb_sensor_sequence_generator;
    import sensor_gen_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    state_t fsm_state;
    int     total = 0;
    int     bad = 0;

    always #5 clk = ~clk;

    sensor_gen_if bus ();

    sensor_sequence_generator #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .PEND_W      (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Detector model: S on entry completion, R on exit completion (combinational).
    int   det;
    logic s_pulse, r_pulse;
    logic [1:0] ab;
    assign ab      = {bus.a, bus.b};
    assign s_pulse = (det == 3) && (ab == 2'b00);
    assign r_pulse = (det == 6) && (ab == 2'b00);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) det <= 0;
        else begin
            case (det)
                0: det <= (ab == 2'b10) ? 1 : (ab == 2'b01) ? 4 : 0;
                1: det <= (ab == 2'b10) ? 1 : (ab == 2'b11) ? 2 : 0;
                2: det <= (ab == 2'b11) ? 2 : (ab == 2'b01) ? 3 : 0;
                3: det <= (ab == 2'b01) ? 3 : 0;
                4: det <= (ab == 2'b01) ? 4 : (ab == 2'b11) ? 5 : 0;
                5: det <= (ab == 2'b11) ? 5 : (ab == 2'b10) ? 6 : 0;
                6: det <= (ab == 2'b10) ? 6 : 0;
                default: det <= 0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Leaves the bench at the start of cycle 0, generator idle.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.enter_req = 1'b0;
        bus.exit_req  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample(input logic e, input logic x);
        bus.enter_req = e;
        bus.exit_req  = x;
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    // Hand timing at HOLD=4: PH1 offsets 0-3, PH2 4-7, PH3 8-11, then 00.
    function automatic logic [1:0] seq_pat(input int c, input int start, input logic d);
        int off;
        off = c - start;
        if (off < 0 || off >= 12) return 2'b00;
        if (off < 4) return d ? 2'b01 : 2'b10;
        if (off < 8) return 2'b11;
        return d ? 2'b10 : 2'b01;
    endfunction

    initial begin
        int dones;
        int s_cnt;
        int r_cnt;

        // Reset values and single entry: request in cycle 10.
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            to_sample(c == 10, 1'b0);
            if (c == 0) begin
                check("rst_state", fsm_state, IDLE);
                check("rst_dir", bus.dir, 1'b0);
                check("rst_ovf", bus.ovf, 1'b0);
            end
            check("single_ab", ab, seq_pat(c, 12, 1'b0));
            check("single_busy", bus.busy, (c >= 12 && c <= 25));
            check("single_done", bus.done, (c == 24));
            if (c == 24) check("single_dir", bus.dir, 1'b0);
            to_next();
        end

        // Tie in cycle 5: entry first (cycle 7), then exit (cycle 23).
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            to_sample(c == 5, c == 5);
            check("tie_ab", ab, seq_pat(c, 7, 1'b0) | seq_pat(c, 23, 1'b1));
            check("tie_done", bus.done, (c == 19 || c == 35));
            if (c == 19) check("tie_dir0", bus.dir, 1'b0);
            if (c == 35) check("tie_dir1", bus.dir, 1'b1);
            to_next();
        end

        // Back-to-back exits in cycles 0-2: starts at 2, 18, 34.
        do_reset();
        for (int c = 0; c <= 52; c++) begin
            to_sample(1'b0, c <= 2);
            check("b2b_ab", ab, seq_pat(c, 2, 1'b1) | seq_pat(c, 18, 1'b1) | seq_pat(c, 34, 1'b1));
            check("b2b_ovf", bus.ovf, 1'b0);
            if (c == 14 || c == 30 || c == 46) check("b2b_dir", bus.dir, 1'b1);
            to_next();
        end

        // Saturation: 8 entry requests during an exit car; the 8th is dropped.
        do_reset();
        dones = 0;
        for (int c = 0; c <= 135; c++) begin
            to_sample(c >= 3 && c <= 10, c == 0);
            check("sat_ovf", bus.ovf, (c == 11));
            if (bus.done) dones++;
            if (c == 114) check("sat_last_ab", ab, 2'b10);
            if (c == 126) check("sat_last_done", bus.done, 1'b1);
            if (c == 130) check("sat_idle_busy", bus.busy, 1'b0);
            to_next();
        end
        check("sat_dones", dones, 8);

        // Async reset during PH2 of an entry with 2 exits pending.
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            to_sample(c == 0, c <= 1);
            if (c == 7) check("mid_ph2_ab", ab, 2'b11);
            if (c < 7) to_next();
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_ab", ab, 2'b00);
        check("async_busy", bus.busy, 1'b0);
        check("async_state", fsm_state, IDLE);
        bus.enter_req = 1'b0;
        bus.exit_req  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        to_next();
        for (int c = 0; c < 40; c++) begin
            to_sample(1'b0, 1'b0);
            check("post_rst_busy", bus.busy, 1'b0);
            check("post_rst_ab", ab, 2'b00);
            to_next();
        end

        // Closed loop: 3 entries and 2 exits interleaved.
        do_reset();
        s_cnt = 0;
        r_cnt = 0;
        for (int c = 0; c <= 110; c++) begin
            to_sample(c == 0 || c == 3 || c == 6, c == 1 || c == 5);
            if (s_pulse) s_cnt++;
            if (r_pulse) r_cnt++;
            check("cl_done", bus.done, s_pulse | r_pulse);
            if (bus.done) check("cl_dir", bus.dir, r_pulse);
            to_next();
        end
        check("cl_s_cnt", s_cnt, 3);
        check("cl_r_cnt", r_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
